teak_action_fill_gmem: RTL and testbench
========================================

# teak_action_fill_gmem

Parametrised kernel action that fills a region of shared memory through a single AXI master (gmem). On a go handshake it reads four words from the parameter register file, then writes an incrementing 32-bit pattern with INCR bursts that never cross a 4 KB boundary, and completes with a done handshake. It occupies the kernel-action slot in the go-teak SDAccel top level. Its main use is as a bring-up and bandwidth action for the memory path.

## Interface
Parameters:
- ADDR_WIDTH, 64, gmem address width (>= 32)
- DATA_WIDTH, 32, gmem data width; power of two, 32..512
- ID_WIDTH, 1, AXI ID width
- MAX_BURST, 16, maximum beats per burst; power of two, 1..256

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- go_0r / go_0a  in / out  1 / 1  start request / acknowledge
- done_0r / done_0a  out / in  1 / 1  completion request / acknowledge
- param_addr_0r / param_addr / param_addr_0a  out / out / in  1 / 32 / 1  parameter index request
- param_data_0r / param_data / param_data_0a  in / in / out  1 / 32 / 1  parameter data return
- m_axi_gmem_awaddr  out  ADDR_WIDTH  burst address
- m_axi_gmem_awlen  out  8  beats-1
- m_axi_gmem_awsize / awburst / awcache / awprot  out  3/2/4/3  log2(DATA_WIDTH/8) / 2'b01 / 4'b0011 / 3'b000
- m_axi_gmem_awid  out  ID_WIDTH  constant 0
- m_axi_gmem_awvalid / awready  out / in  1 / 1
- m_axi_gmem_wdata / wstrb / wlast  out  DATA_WIDTH / DATA_WIDTH/8 / 1  wstrb all ones
- m_axi_gmem_wvalid / wready  out / in  1 / 1
- m_axi_gmem_bresp / bid / bvalid / bready  in/in/in/out  2 / ID_WIDTH / 1 / 1

## Operation
- Parameters, by index: 0 = base address low, 1 = base address high (ignored above ADDR_WIDTH), 2 = beat count N, 3 = seed S.
- Base address low log2(DATA_WIDTH/8) bits are forced to zero.
- States:
  - IDLE: go_0r=1 -> pulse go_0a for one cycle -> PREQ with index 0.
  - PREQ: drive param_addr_0r with param_addr=index until param_addr_0a=1 -> PRSP.
  - PRSP: wait for param_data_0r; capture param_data; pulse param_data_0a for one cycle; index++. Index<4 -> PREQ. Else N=0 -> DONE, N>0 -> AW.
  - AW: burst length L = min(MAX_BURST, remaining, beats left to next 4 KB boundary). Hold awvalid until awready -> W.
  - W: send L beats; wlast on beat L-1 -> B.
  - B: bready=1. On bvalid: remaining>0 -> AW, else DONE.
  - DONE: hold done_0r until done_0a sampled 1 -> IDLE.
- Beat data: lane k (32 bits) of global beat i = S + i*(DATA_WIDTH/32) + k, modulo 2^32.
- Exactly one burst is in flight at a time. Address increments by L*DATA_WIDTH/8 per burst; 64-bit address wrap is not checked.
- go_0r is ignored outside IDLE.

## Timing
- Reset: every output is 0 except the constant AXI attribute fields. State returns to IDLE on the first edge with reset_n=0, including mid-burst; any in-flight AXI transaction is abandoned.
- go_0a is high the cycle after go_0r is sampled in IDLE.
- param_addr_0r is asserted the cycle PREQ is entered.
- awvalid is asserted the cycle after the last parameter is captured, or the cycle after B completes.
- wvalid rises the cycle after the AW handshake. With wready held high, the burst takes L consecutive cycles.
- bready is asserted from B entry.
- Valid/payload stability: once awvalid or wvalid is raised, it and its payload stay stable until the handshake.
- done_0r rises the cycle after the final B handshake, or directly after PRSP when N=0. It drops the cycle after done_0a is sampled high.

## Configuration
- TEAK_FILL_BRESP_ABORT_EN defined: a bresp other than OKAY moves B directly to DONE; the remaining bursts are skipped.
- TEAK_FILL_BRESP_ABORT_EN undefined: bresp is ignored and all N beats are written.

## Test plan
- DATA_WIDTH=32, MAX_BURST=16, base 0x1000, N=40, S=0x10 -> bursts of awlen 15,15,7 at 0x1000/0x1040/0x1080; last wdata 0x37; then done_0r.
- Base 0x0FF8, N=8, MAX_BURST=16 -> two bursts of 2 and 6 beats at 0x0FF8 and 0x1000 (no 4 KB crossing).
- DATA_WIDTH=128, N=2, S=0xFFFFFFFE -> beat0 lanes FFFFFFFE, FFFFFFFF, 0, 1; beat1 lanes 2..5.
- N=0 -> no awvalid; done_0r rises right after the fourth param_data_0a.
- Macro defined, first bresp=SLVERR with N=32, MAX_BURST=16 -> one burst only, then done. Macro undefined -> two bursts.
- Random awready/wready/bvalid stalls, plus reset_n low during W -> payloads held stable under stall; after reset all outputs are 0, and a fresh go then completes correctly.

Source files
------------

// File: rtl/teak_action_fill_gmem.sv
// Fill action: reads base/count/seed parameters, then writes an incrementing
// pattern to gmem in 4 KB-safe INCR bursts. Option: TEAK_FILL_BRESP_ABORT_EN.
module teak_action_fill_gmem #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 1,
   parameter int MAX_BURST  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    go_0r,
   output logic                    go_0a,
   output logic                    done_0r,
   input  logic                    done_0a,
   output logic                    param_addr_0r,
   output logic [31:0]             param_addr,
   input  logic                    param_addr_0a,
   input  logic                    param_data_0r,
   input  logic [31:0]             param_data,
   output logic                    param_data_0a,
   output logic [ADDR_WIDTH-1:0]   m_axi_gmem_awaddr,
   output logic [7:0]              m_axi_gmem_awlen,
   output logic [2:0]              m_axi_gmem_awsize,
   output logic [1:0]              m_axi_gmem_awburst,
   output logic [3:0]              m_axi_gmem_awcache,
   output logic [2:0]              m_axi_gmem_awprot,
   output logic [ID_WIDTH-1:0]     m_axi_gmem_awid,
   output logic                    m_axi_gmem_awvalid,
   input  logic                    m_axi_gmem_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_gmem_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_gmem_wstrb,
   output logic                    m_axi_gmem_wlast,
   output logic                    m_axi_gmem_wvalid,
   input  logic                    m_axi_gmem_wready,
   input  logic [1:0]              m_axi_gmem_bresp,
   input  logic [ID_WIDTH-1:0]     m_axi_gmem_bid,
   input  logic                    m_axi_gmem_bvalid,
   output logic                    m_axi_gmem_bready
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int SZ    = $clog2(BYTES);
   localparam int LANES = DATA_WIDTH / 32;
   localparam logic [31:0] LO_MASK = ~32'(BYTES - 1);

   typedef enum logic [2:0] {
      IDLE, PREQ, PRSP, AW, W, B, DONE
   } state_t;

   state_t state, state_nx;

   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0] remaining;
   logic [31:0] pattern;
   logic [1:0]  idx;
   logic [8:0]  len;
   logic [8:0]  cnt;
   logic        go_ack;

   logic [12:0] to4k;
   logic [12:0] room;
   logic [31:0] lim;
   logic [31:0] blen;
   logic [8:0]  len_c;
   logic [8:0]  len_m1;
   logic        last_beat;
   logic        aw_hs;
   logic        w_hs;
   logic        pd_hs;
   logic        unused;

   // burst length limited by MAX_BURST, beats left, and the next 4 KB page
   always_comb begin
      to4k   = 13'h1000 - {1'b0, addr[11:0]};
      room   = to4k >> SZ;
      lim    = (32'(room) < 32'(MAX_BURST)) ? 32'(room) : 32'(MAX_BURST);
      blen   = (remaining < lim) ? remaining : lim;
      len_c  = blen[8:0];
      len_m1 = len_c - 9'd1;
   end

   assign last_beat = (cnt == len - 9'd1);
   assign aw_hs     = (state == AW) && m_axi_gmem_awready;
   assign w_hs      = (state == W) && m_axi_gmem_wready;
   assign pd_hs     = (state == PRSP) && param_data_0r;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (go_0r) state_nx = PREQ;
         PREQ: if (param_addr_0a) state_nx = PRSP;
         PRSP: begin
            if (param_data_0r) begin
               if (idx != 2'd3)         state_nx = PREQ;
               else if (remaining == 0) state_nx = DONE;
               else                     state_nx = AW;
            end
         end
         AW: if (m_axi_gmem_awready) state_nx = W;
         W:  if (m_axi_gmem_wready && last_beat) state_nx = B;
         B: begin
            if (m_axi_gmem_bvalid) begin
`ifdef TEAK_FILL_BRESP_ABORT_EN
               if (m_axi_gmem_bresp != 2'b00) state_nx = DONE;
               else if (remaining != 0)       state_nx = AW;
               else                           state_nx = DONE;
`else
               if (remaining != 0) state_nx = AW;
               else                state_nx = DONE;
`endif
            end
         end
         DONE: if (done_0a) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         go_ack    <= 1'b0;
         idx       <= 2'd0;
         addr      <= '0;
         remaining <= '0;
         pattern   <= '0;
         len       <= '0;
         cnt       <= '0;
      end else begin
         go_ack <= (state == IDLE) && go_0r;
         if ((state == IDLE) && go_0r) idx <= 2'd0;
         if (pd_hs) begin
            idx <= idx + 2'd1;
            unique case (idx)
               2'd0: addr <= ADDR_WIDTH'(param_data & LO_MASK);
               2'd1: addr <= ADDR_WIDTH'({param_data, addr[31:0]});
               2'd2: remaining <= param_data;
               2'd3: pattern <= param_data;
               default: ;
            endcase
         end
         if (aw_hs) begin
            len       <= len_c;
            cnt       <= '0;
            addr      <= addr + (ADDR_WIDTH'(len_c) << SZ);
            remaining <= remaining - 32'(len_c);
         end
         if (w_hs) begin
            cnt     <= cnt + 9'd1;
            pattern <= pattern + 32'(LANES);
         end
      end
   end

   assign go_0a         = go_ack;
   assign done_0r       = (state == DONE);
   assign param_addr_0r = (state == PREQ);
   assign param_addr    = {30'd0, idx};
   assign param_data_0a = pd_hs;

   assign m_axi_gmem_awvalid = (state == AW);
   assign m_axi_gmem_awaddr  = m_axi_gmem_awvalid ? addr : '0;
   assign m_axi_gmem_awlen   = m_axi_gmem_awvalid ? len_m1[7:0] : '0;
   assign m_axi_gmem_awsize  = 3'(SZ);
   assign m_axi_gmem_awburst = 2'b01;
   assign m_axi_gmem_awcache = 4'b0011;
   assign m_axi_gmem_awprot  = 3'b000;
   assign m_axi_gmem_awid    = '0;
   assign m_axi_gmem_wvalid  = (state == W);
   assign m_axi_gmem_wlast   = m_axi_gmem_wvalid && last_beat;
   assign m_axi_gmem_wstrb   = '1;
   assign m_axi_gmem_bready  = (state == B);

   always_comb begin
      m_axi_gmem_wdata = '0;
      if (state == W) begin
         for (int k = 0; k < LANES; k++) begin
            m_axi_gmem_wdata[32*k +: 32] = pattern + 32'(k);
         end
      end
   end

`ifdef TEAK_FILL_BRESP_ABORT_EN
   assign unused = ^{m_axi_gmem_bid, blen[31:9], len_m1[8]};
`else
   assign unused = ^{m_axi_gmem_bid, m_axi_gmem_bresp, blen[31:9], len_m1[8]};
`endif

endmodule

// File: tb/tb_teak_action_fill_gmem.sv
// Directed bench for teak_action_fill_gmem: a 32-bit and a 128-bit instance
// share one parameter responder and one AXI write slave; sel picks the active one.
module tb_teak_action_fill_gmem;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic go = 1'b0;
   logic sel = 1'b0;
   logic done_ack = 1'b0;
   logic pa_ack = 1'b0;
   logic pd_req = 1'b0;
   logic [31:0] pd = '0;
   logic awready = 1'b0;
   logic wready = 1'b0;
   logic bvalid = 1'b0;
   logic [1:0] bresp = 2'b00;
   logic bid = 1'b0;
   logic go_in_a, go_in_b;

   logic go_ack_a, done_a, pa_r_a, pd_ack_a, awvalid_a, wvalid_a, wlast_a;
   logic bready_a, awid_a;
   logic [31:0] pa_v_a, wdata_a;
   logic [63:0] awaddr_a;
   logic [7:0] awlen_a;
   logic [2:0] awsize_a, awprot_a;
   logic [1:0] awburst_a;
   logic [3:0] awcache_a, wstrb_a;

   logic go_ack_b, done_b, pa_r_b, pd_ack_b, awvalid_b, wvalid_b, wlast_b;
   logic bready_b, awid_b;
   logic [31:0] pa_v_b;
   logic [127:0] wdata_b;
   logic [63:0] awaddr_b;
   logic [7:0] awlen_b;
   logic [2:0] awsize_b, awprot_b;
   logic [1:0] awburst_b;
   logic [3:0] awcache_b;
   logic [15:0] wstrb_b;

   logic go_ack_m, done_m, pa_r_m, pd_ack_m, awvalid_m, wvalid_m, wlast_m, bready_m;
   logic [31:0] pa_m;
   logic [63:0] awaddr_m;
   logic [7:0] awlen_m;
   logic [127:0] wdata_m;

   assign go_in_a   = go && !sel;
   assign go_in_b   = go && sel;
   assign go_ack_m  = sel ? go_ack_b : go_ack_a;
   assign done_m    = sel ? done_b : done_a;
   assign pa_r_m    = sel ? pa_r_b : pa_r_a;
   assign pa_m      = sel ? pa_v_b : pa_v_a;
   assign pd_ack_m  = sel ? pd_ack_b : pd_ack_a;
   assign awvalid_m = sel ? awvalid_b : awvalid_a;
   assign awaddr_m  = sel ? awaddr_b : awaddr_a;
   assign awlen_m   = sel ? awlen_b : awlen_a;
   assign wvalid_m  = sel ? wvalid_b : wvalid_a;
   assign wlast_m   = sel ? wlast_b : wlast_a;
   assign wdata_m   = sel ? wdata_b : {96'd0, wdata_a};
   assign bready_m  = sel ? bready_b : bready_a;

   teak_action_fill_gmem #(
      .ADDR_WIDTH(64), .DATA_WIDTH(32), .ID_WIDTH(1), .MAX_BURST(16)
   ) u_a (
      .clk(clk), .reset_n(reset_n),
      .go_0r(go_in_a), .go_0a(go_ack_a),
      .done_0r(done_a), .done_0a(done_ack),
      .param_addr_0r(pa_r_a), .param_addr(pa_v_a), .param_addr_0a(pa_ack),
      .param_data_0r(pd_req), .param_data(pd), .param_data_0a(pd_ack_a),
      .m_axi_gmem_awaddr(awaddr_a), .m_axi_gmem_awlen(awlen_a),
      .m_axi_gmem_awsize(awsize_a), .m_axi_gmem_awburst(awburst_a),
      .m_axi_gmem_awcache(awcache_a), .m_axi_gmem_awprot(awprot_a),
      .m_axi_gmem_awid(awid_a), .m_axi_gmem_awvalid(awvalid_a),
      .m_axi_gmem_awready(awready), .m_axi_gmem_wdata(wdata_a),
      .m_axi_gmem_wstrb(wstrb_a), .m_axi_gmem_wlast(wlast_a),
      .m_axi_gmem_wvalid(wvalid_a), .m_axi_gmem_wready(wready),
      .m_axi_gmem_bresp(bresp), .m_axi_gmem_bid(bid),
      .m_axi_gmem_bvalid(bvalid), .m_axi_gmem_bready(bready_a)
   );

   teak_action_fill_gmem #(
      .ADDR_WIDTH(64), .DATA_WIDTH(128), .ID_WIDTH(1), .MAX_BURST(16)
   ) u_b (
      .clk(clk), .reset_n(reset_n),
      .go_0r(go_in_b), .go_0a(go_ack_b),
      .done_0r(done_b), .done_0a(done_ack),
      .param_addr_0r(pa_r_b), .param_addr(pa_v_b), .param_addr_0a(pa_ack),
      .param_data_0r(pd_req), .param_data(pd), .param_data_0a(pd_ack_b),
      .m_axi_gmem_awaddr(awaddr_b), .m_axi_gmem_awlen(awlen_b),
      .m_axi_gmem_awsize(awsize_b), .m_axi_gmem_awburst(awburst_b),
      .m_axi_gmem_awcache(awcache_b), .m_axi_gmem_awprot(awprot_b),
      .m_axi_gmem_awid(awid_b), .m_axi_gmem_awvalid(awvalid_b),
      .m_axi_gmem_awready(awready), .m_axi_gmem_wdata(wdata_b),
      .m_axi_gmem_wstrb(wstrb_b), .m_axi_gmem_wlast(wlast_b),
      .m_axi_gmem_wvalid(wvalid_b), .m_axi_gmem_wready(wready),
      .m_axi_gmem_bresp(bresp), .m_axi_gmem_bid(bid),
      .m_axi_gmem_bvalid(bvalid), .m_axi_gmem_bready(bready_b)
   );

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] prm [4];
   int pidx = 0;
   logic stall = 1'b0;
   logic err_next = 1'b0;
   logic [31:0] exp_seed = '0;
   int naw = 0;
   int nw = 0;
   int bb = 0;
   int blen_exp = 0;
   int bpend = 0;
   logic b_done = 1'b0;
   logic [63:0] aw_log_addr [16];
   logic [7:0] aw_log_len [16];
   logic [127:0] wlog [64];

   logic aw_stall, w_stall;
   logic [63:0] aw_prev_addr;
   logic [7:0] aw_prev_len;
   logic [127:0] w_prev_data;
   logic w_prev_last;

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] expw(input int lanes, input logic [31:0] s,
                                         input int i);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < lanes; k++) r[32*k +: 32] = s + 32'(i * lanes + k);
      return r;
   endfunction

   // parameter register file responder
   initial forever begin
      @(negedge clk);
      if (reset_n && pa_r_m) begin
         check("param_addr", pa_m, pidx);
         pa_ack = 1'b1;
         @(negedge clk);
         pa_ack = 1'b0;
         pd = prm[pidx[1:0]];
         pd_req = 1'b1;
         #1 check("param_data_0a", pd_ack_m, 1);
         pidx++;
         @(negedge clk);
         pd_req = 1'b0;
         if (pidx == 4) begin
            #1;
            check("done_0r after params", done_m, prm[2] == 0);
            check("awvalid after params", awvalid_m, prm[2] != 0);
         end
      end
   end

   // AXI write slave with optional random stalls and stability checks
   initial begin
      aw_stall = 1'b0;
      w_stall = 1'b0;
      aw_prev_addr = '0;
      aw_prev_len = '0;
      w_prev_data = '0;
      w_prev_last = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            awready = 1'b0;
            wready = 1'b0;
            bvalid = 1'b0;
            bpend = 0;
            b_done = 1'b0;
            aw_stall = 1'b0;
            w_stall = 1'b0;
         end else begin
            if (b_done) begin
               bvalid = 1'b0;
               b_done = 1'b0;
            end
            if (!bvalid && bpend > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
               bvalid = 1'b1;
               bresp = err_next ? 2'b10 : 2'b00;
               err_next = 1'b0;
            end
            awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (aw_stall) begin
               check("awvalid held", awvalid_m, 1);
               check("awaddr held", awaddr_m, aw_prev_addr);
               check("awlen held", awlen_m, aw_prev_len);
            end
            if (w_stall) begin
               check("wvalid held", wvalid_m, 1);
               check("wdata held", wdata_m, w_prev_data);
               check("wlast held", wlast_m, w_prev_last);
            end
            aw_stall = awvalid_m && !awready;
            aw_prev_addr = awaddr_m;
            aw_prev_len = awlen_m;
            w_stall = wvalid_m && !wready;
            w_prev_data = wdata_m;
            w_prev_last = wlast_m;
            if (awvalid_m && awready) begin
               if (naw < 16) begin
                  aw_log_addr[naw] = awaddr_m;
                  aw_log_len[naw] = awlen_m;
               end
               naw++;
               blen_exp = int'(awlen_m);
               bb = 0;
            end
            if (wvalid_m && wready) begin
               check("wdata", wdata_m, expw(sel ? 4 : 1, exp_seed, nw));
               check("wlast", wlast_m, bb == blen_exp);
               if (nw < 64) wlog[nw] = wdata_m;
               nw++;
               bb++;
               if (wlast_m) bpend++;
            end
            if (bvalid && bready_m) begin
               bpend--;
               b_done = 1'b1;
            end
         end
      end
   end

   task automatic start(input logic s, input logic [31:0] lo, input logic [31:0] hi,
                        input logic [31:0] n, input logic [31:0] seed);
      sel = s;
      prm[0] = lo;
      prm[1] = hi;
      prm[2] = n;
      prm[3] = seed;
      pidx = 0;
      naw = 0;
      nw = 0;
      exp_seed = seed;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      check("go_0a", go_ack_m, 1);
      check("param_addr_0r on PREQ", pa_r_m, 1);
      go = 1'b0;
      @(negedge clk);
      check("go_0a pulse", go_ack_m, 0);
   endtask

   task automatic finish_run();
      int c;
      c = 0;
      while (!done_m && c < 3000) begin
         @(negedge clk);
         c++;
      end
      if (!done_m) begin
         check("done timeout", 0, 1);
      end else begin
         done_ack = 1'b1;
         @(negedge clk);
         check("done_0r drop", done_m, 0);
         done_ack = 1'b0;
      end
   endtask

   task automatic run(input logic s, input logic [31:0] lo, input logic [31:0] hi,
                      input logic [31:0] n, input logic [31:0] seed);
      start(s, lo, hi, n, seed);
      finish_run();
   endtask

   task automatic check_idle(input string tag);
      check({tag, " go_0a"}, go_ack_a, 0);
      check({tag, " done_0r"}, done_a, 0);
      check({tag, " param_addr_0r"}, pa_r_a, 0);
      check({tag, " param_addr"}, pa_v_a, 0);
      check({tag, " param_data_0a"}, pd_ack_a, 0);
      check({tag, " awvalid"}, awvalid_a, 0);
      check({tag, " awaddr"}, awaddr_a, 0);
      check({tag, " awlen"}, awlen_a, 0);
      check({tag, " wvalid"}, wvalid_a, 0);
      check({tag, " wdata"}, wdata_a, 0);
      check({tag, " wlast"}, wlast_a, 0);
      check({tag, " bready"}, bready_a, 0);
      check({tag, " wdata_b"}, wdata_b, 0);
   endtask

   initial begin
      int c;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check("awsize", awsize_a, 3'd2);
      check("awburst", awburst_a, 2'b01);
      check("awcache", awcache_a, 4'b0011);
      check("awprot", awprot_a, 3'b000);
      check("awid", awid_a, 0);
      check("wstrb", wstrb_a, 4'hF);
      check("awsize_b", awsize_b, 3'd4);
      check("wstrb_b", wstrb_b, 16'hFFFF);
      reset_n = 1'b1;
      @(negedge clk);

      run(1'b0, 32'h1000, 32'h0, 32'd40, 32'h10);
      check("t1 bursts", naw, 3);
      check("t1 aw0", {aw_log_addr[0], aw_log_len[0]}, {64'h1000, 8'd15});
      check("t1 aw1", {aw_log_addr[1], aw_log_len[1]}, {64'h1040, 8'd15});
      check("t1 aw2", {aw_log_addr[2], aw_log_len[2]}, {64'h1080, 8'd7});
      check("t1 beats", nw, 40);
      check("t1 last wdata", wlog[39], 128'h37);

      run(1'b0, 32'h0FF8, 32'h0, 32'd8, 32'h0);
      check("t2 bursts", naw, 2);
      check("t2 aw0", {aw_log_addr[0], aw_log_len[0]}, {64'h0FF8, 8'd1});
      check("t2 aw1", {aw_log_addr[1], aw_log_len[1]}, {64'h1000, 8'd5});
      check("t2 beats", nw, 8);

      run(1'b0, 32'h1000, 32'h0, 32'd0, 32'h5);
      check("n0 bursts", naw, 0);
      check("n0 beats", nw, 0);

      run(1'b1, 32'h4C, 32'h1, 32'd2, 32'hFFFF_FFFE);
      check("w128 bursts", naw, 1);
      check("w128 aw0", {aw_log_addr[0], aw_log_len[0]}, {64'h1_0000_0040, 8'd1});
      check("w128 beat0", wlog[0], 128'h00000001_00000000_FFFFFFFF_FFFFFFFE);
      check("w128 beat1", wlog[1], 128'h00000005_00000004_00000003_00000002);

      stall = 1'b1;
      run(1'b0, 32'h2000, 32'h0, 32'd20, 32'h100);
      check("stall bursts", naw, 2);
      check("stall aw0", {aw_log_addr[0], aw_log_len[0]}, {64'h2000, 8'd15});
      check("stall aw1", {aw_log_addr[1], aw_log_len[1]}, {64'h2040, 8'd3});
      check("stall last wdata", wlog[19], 128'h113);

      stall = 1'b0;
      err_next = 1'b1;
      run(1'b0, 32'h5000, 32'h0, 32'd32, 32'h0);
`ifdef TEAK_FILL_BRESP_ABORT_EN
      check("abort bursts", naw, 1);
      check("abort beats", nw, 16);
`else
      check("slverr bursts", naw, 2);
      check("slverr beats", nw, 32);
      check("slverr aw1", aw_log_addr[1], 64'h5040);
`endif
      err_next = 1'b0;

      stall = 1'b1;
      start(1'b0, 32'h3000, 32'h0, 32'd40, 32'h0);
      c = 0;
      while (nw < 3 && c < 500) begin
         @(negedge clk);
         c++;
      end
      check("reach W before reset", nw >= 3, 1);
      reset_n = 1'b0;
      @(negedge clk);
      check_idle("mid reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run(1'b0, 32'h3002, 32'h0, 32'd5, 32'h7);
      check("post reset bursts", naw, 1);
      check("post reset aw0", {aw_log_addr[0], aw_log_len[0]}, {64'h3000, 8'd4});
      check("post reset last wdata", wlog[4], 128'hB);
      stall = 1'b0;

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
